// File: rtl/squeeze_ker_fill_sched.sv
// squeeze_ker_fill_sched: loads a kernel set from memory into the squeeze FIFO in bursts
// Ports: clk_i/rst_n_i clock and async active-low reset; start_i/base_addr_i/tot_words_i job launch;
// fifo_count_i/fifo_clr_o/fifo_wr_en_o/fifo_wr_data_o squeeze FIFO side; mem_rd_req_o/mem_rd_addr_o/
// mem_rd_burst_o/mem_rd_ack_i/mem_rd_valid_i/mem_rd_data_i burst read side; busy_o/done_o status.
// Optional macro SQU_FILL_WATCHDOG_EN adds a stall watchdog and the sticky err_o port.
module squeeze_ker_fill_sched #(
   parameter int BURST_LEN  = 16,
   parameter int FIFO_DEPTH = 128
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        start_i,
   input  logic [31:0] base_addr_i,
   input  logic [12:0] tot_words_i,
   input  logic [7:0]  fifo_count_i,
   output logic        fifo_clr_o,
   output logic        fifo_wr_en_o,
   output logic [63:0] fifo_wr_data_o,
   output logic        mem_rd_req_o,
   output logic [31:0] mem_rd_addr_o,
   output logic [6:0]  mem_rd_burst_o,
   input  logic        mem_rd_ack_i,
   input  logic        mem_rd_valid_i,
   input  logic [63:0] mem_rd_data_i,
   output logic        busy_o,
   output logic        done_o
`ifdef SQU_FILL_WATCHDOG_EN
   ,
   output logic        err_o
`endif
);
   typedef enum logic [2:0] {IDLE, CLR, CHECK, REQ, DATA, DONE, ERR} state_t;
   state_t      state_r, state_nxt;
   logic [31:0] addr_r;
   logic [12:0] remain_r;
   logic [6:0]  burst_r, burst_nxt, cnt_r;
   logic        wr_en_r, fits, beat_last;
   logic [63:0] wr_data_r;
   assign burst_nxt = (remain_r > 13'(BURST_LEN)) ? 7'(BURST_LEN) : remain_r[6:0];
   // compare as used + burst <= depth so an over-reported count never wraps into "free"
   assign fits      = 32'(fifo_count_i) + 32'(burst_nxt) <= 32'(FIFO_DEPTH);
   assign beat_last = state_r == DATA && mem_rd_valid_i && cnt_r + 7'd1 == burst_r;
`ifdef SQU_FILL_WATCHDOG_EN
   logic [9:0] wd_r;
   logic       wd_act, wd_trip;
   assign wd_act  = state_r == REQ || state_r == DATA;
   // counter reaches 1023 on this edge, so ERR is entered in the same edge
   assign wd_trip = wd_act && !(mem_rd_ack_i || mem_rd_valid_i) && wd_r == 10'd1022;
   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) wd_r <= '0;
      else wd_r <= (wd_act && !(mem_rd_ack_i || mem_rd_valid_i)) ? wd_r + 10'd1 : '0;
`endif
   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) state_r <= IDLE;
      else state_r <= state_nxt;
   always_comb begin
      state_nxt = state_r;
      case (state_r)
         IDLE:    state_nxt = start_i ? CLR : IDLE;
         CLR:     state_nxt = CHECK;
         CHECK:   state_nxt = remain_r == '0 ? DONE : fits ? REQ : CHECK;
         REQ:     state_nxt = mem_rd_ack_i ? DATA : REQ;
         DATA:    state_nxt = beat_last ? CHECK : DATA;
         DONE:    state_nxt = IDLE;
         default: state_nxt = state_r;
      endcase
`ifdef SQU_FILL_WATCHDOG_EN
      if (wd_trip) state_nxt = ERR;
`endif
   end
   always_comb begin
      fifo_clr_o     = state_r == CLR;
      fifo_wr_en_o   = wr_en_r;
      fifo_wr_data_o = wr_data_r;
      mem_rd_req_o   = state_r == REQ;
      mem_rd_addr_o  = state_r == REQ ? addr_r : '0;
      mem_rd_burst_o = state_r == REQ ? burst_r : '0;
      busy_o         = state_r != IDLE;
      done_o         = state_r == DONE;
`ifdef SQU_FILL_WATCHDOG_EN
      err_o          = state_r == ERR;
`endif
   end
   // beats are only accepted in DATA; anything else on the read channel is dropped
   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) begin
         addr_r    <= '0;
         remain_r  <= '0;
         burst_r   <= '0;
         cnt_r     <= '0;
         wr_en_r   <= 1'b0;
         wr_data_r <= '0;
      end else begin
         wr_en_r <= state_r == DATA && mem_rd_valid_i;
         if (state_r == DATA && mem_rd_valid_i) wr_data_r <= mem_rd_data_i;
         if (state_r == IDLE && start_i) begin
            addr_r   <= base_addr_i;
            remain_r <= tot_words_i;
         end
         if (state_r == CHECK) burst_r <= burst_nxt;
         if (state_r == REQ) cnt_r <= '0;
         else if (beat_last) begin
            cnt_r    <= '0;
            addr_r   <= addr_r + {22'd0, burst_r, 3'd0};
            remain_r <= remain_r - {6'd0, burst_r};
         end else if (state_r == DATA && mem_rd_valid_i) cnt_r <= cnt_r + 7'd1;
      end
endmodule

// File: tb/tb_squeeze_ker_fill_sched.sv
// tb_squeeze_ker_fill_sched: randomized self-checking bench with a burst-list/beat-queue reference model
module tb_squeeze_ker_fill_sched;
   localparam int BL = 16;
   localparam int FD = 128;
   logic        clk = 1'b0;
   logic        rst_n_i, start_i, mem_rd_ack_i, mem_rd_valid_i;
   logic [31:0] base_addr_i;
   logic [12:0] tot_words_i;
   logic [7:0]  fifo_count_i;
   logic [63:0] mem_rd_data_i;
   logic        fifo_clr_o, fifo_wr_en_o, mem_rd_req_o, busy_o, done_o;
   logic [63:0] fifo_wr_data_o;
   logic [31:0] mem_rd_addr_o;
   logic [6:0]  mem_rd_burst_o;
   int          checks = 0, failures = 0;
   logic [31:0] exp_addr[$];
   logic [6:0]  exp_len[$];
   logic [63:0] exp_data[$];
   logic        auto_mem, spurious, stray_start, rand_fc, req_open;
   logic [31:0] req_a;
   logic [6:0]  req_b;
   int          pend, ack_wait, n_wr, n_clr, n_done, lat;
   squeeze_ker_fill_sched #(.BURST_LEN(BL), .FIFO_DEPTH(FD)) dut (
      .clk_i(clk), .rst_n_i(rst_n_i), .start_i(start_i), .base_addr_i(base_addr_i),
      .tot_words_i(tot_words_i), .fifo_count_i(fifo_count_i), .fifo_clr_o(fifo_clr_o),
      .fifo_wr_en_o(fifo_wr_en_o), .fifo_wr_data_o(fifo_wr_data_o), .mem_rd_req_o(mem_rd_req_o),
      .mem_rd_addr_o(mem_rd_addr_o), .mem_rd_burst_o(mem_rd_burst_o), .mem_rd_ack_i(mem_rd_ack_i),
      .mem_rd_valid_i(mem_rd_valid_i), .mem_rd_data_i(mem_rd_data_i), .busy_o(busy_o), .done_o(done_o)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic build_exp(input logic [31:0] base, input int tot);
      int off = 0;
      while (off < tot) begin
         int n = (tot - off > BL) ? BL : tot - off;
         exp_addr.push_back(base + 32'(off * 8));
         exp_len.push_back(7'(n));
         off += n;
      end
   endtask
   task automatic cyc();
      @(posedge clk);
      #1;
      start_i = 1'b0;
      mem_rd_ack_i = 1'b0;
      mem_rd_valid_i = 1'b0;
      if (fifo_wr_en_o) begin
         n_wr++;
         if (exp_data.size() == 0) chk("wr_unexpected", fifo_wr_en_o, 1'b0);
         else chk("wr_data", fifo_wr_data_o, exp_data.pop_front());
      end
      if (fifo_clr_o) n_clr++;
      if (done_o) n_done++;
      if (mem_rd_req_o) begin
         chk("one_outstanding", 64'(pend), 0);
         if (!req_open) begin
            if (exp_addr.size() == 0) chk("req_unexpected", mem_rd_req_o, 1'b0);
            else begin
               req_open = 1'b1;
               req_a = exp_addr.pop_front();
               req_b = exp_len.pop_front();
               chk("req_addr", mem_rd_addr_o, req_a);
               chk("req_burst", mem_rd_burst_o, req_b);
               ack_wait = $urandom_range(0, 2);
            end
         end else begin
            chk("req_addr_hold", mem_rd_addr_o, req_a);
            chk("req_burst_hold", mem_rd_burst_o, req_b);
         end
         if (auto_mem && req_open) begin
            if (ack_wait == 0) begin
               mem_rd_ack_i = 1'b1;
               pend = int'(req_b);
               req_open = 1'b0;
            end else ack_wait--;
         end
      end else if (auto_mem && pend > 0 && $urandom_range(0, 3) != 0) begin
         mem_rd_valid_i = 1'b1;
         mem_rd_data_i = {$urandom, $urandom};
         exp_data.push_back(mem_rd_data_i);
         pend--;
      end else if (spurious && pend == 0 && $urandom_range(0, 3) == 0) begin
         mem_rd_valid_i = 1'b1;
         mem_rd_data_i = {$urandom, $urandom};
      end
      if (stray_start && busy_o && $urandom_range(0, 5) == 0) begin
         start_i = 1'b1;
         base_addr_i = $urandom;
         tot_words_i = 13'($urandom);
      end
      if (rand_fc) fifo_count_i = 8'($urandom_range(0, FD - BL));
   endtask
   task automatic launch(input logic [31:0] base, input int tot);
      build_exp(base, tot);
      n_wr = 0; n_clr = 0; n_done = 0;
      base_addr_i = base;
      tot_words_i = 13'(tot);
      start_i = 1'b1;
      cyc();
      chk("clr_first", fifo_clr_o, 1'b1);
   endtask
   task automatic finish(input int tot, output int n);
      n = 1;
      while (!done_o && n < 3000) begin
         chk("busy_run", busy_o, 1'b1);
         cyc();
         n++;
      end
      chk("done_seen", done_o, 1'b1);
      cyc();
      chk("done_single", done_o, 1'b0);
      chk("idle_busy", busy_o, 1'b0);
      chk("clr_count", 64'(n_clr), 1);
      chk("done_count", 64'(n_done), 1);
      chk("wr_count", 64'(n_wr), 64'(tot));
      chk("bursts_left", 64'(exp_addr.size()), 0);
      chk("beats_left", 64'(exp_data.size()), 0);
   endtask
   task automatic run(input logic [31:0] base, input int tot);
      launch(base, tot);
      finish(tot, lat);
   endtask
   initial begin
      rst_n_i = 1'b0; start_i = 1'b1; mem_rd_valid_i = 1'b1; mem_rd_ack_i = 1'b1;
      mem_rd_data_i = '1; base_addr_i = 32'h1000; tot_words_i = 13'd5; fifo_count_i = 8'd0;
      auto_mem = 1'b1; spurious = 1'b0; stray_start = 1'b0; rand_fc = 1'b0; req_open = 1'b0;
      pend = 0; ack_wait = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ctrl", {fifo_clr_o, fifo_wr_en_o, mem_rd_req_o, busy_o, done_o}, 0);
      chk("rst_wdata", fifo_wr_data_o, 0);
      chk("rst_addr", mem_rd_addr_o, 0);
      chk("rst_burst", mem_rd_burst_o, 0);
      start_i = 1'b0; mem_rd_valid_i = 1'b0; mem_rd_ack_i = 1'b0;
      @(negedge clk) rst_n_i = 1'b1;
      run(32'h1000, 40);
      launch(32'h2000, 0);
      finish(0, lat);
      chk("zero_latency", 64'(lat), 3);
      rand_fc = 1'b0;
      spurious = 1'b1;
      fifo_count_i = 8'd120;
      launch(32'h3000, 16);
      repeat (6) begin cyc(); chk("hold_check", mem_rd_req_o, 1'b0); end
      fifo_count_i = 8'd113;
      repeat (3) begin cyc(); chk("hold_113", mem_rd_req_o, 1'b0); end
      fifo_count_i = 8'd112;
      cyc();
      chk("req_at_112", mem_rd_req_o, 1'b1);
      fifo_count_i = 8'd0;
      finish(16, lat);
      stray_start = 1'b1;
      rand_fc = 1'b1;
      run(32'hFFFF_FFC0, 20);
      run(32'h0000_8000, 1);
      run(32'h0000_9000, 17);
      for (int t = 0; t < 6; t++) run($urandom & 32'hFFFF_FFF8, $urandom_range(1, 90));
      auto_mem = 1'b0; spurious = 1'b0; stray_start = 1'b0; rand_fc = 1'b0; fifo_count_i = 8'd0;
      launch(32'h4000, 16);
      while (!mem_rd_req_o && n_wr < 1000) begin cyc(); n_wr++; end
      chk("rst_test_req", mem_rd_req_o, 1'b1);
      mem_rd_ack_i = 1'b1;
      req_open = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         mem_rd_valid_i = 1'b1;
         mem_rd_data_i = {$urandom, $urandom};
         exp_data.push_back(mem_rd_data_i);
      end
      cyc();
      cyc();
      chk("five_beats_written", 64'(exp_data.size()), 0);
      #2 rst_n_i = 1'b0;
      #1;
      chk("midrst_ctrl", {fifo_clr_o, fifo_wr_en_o, mem_rd_req_o, busy_o, done_o}, 0);
      chk("midrst_wdata", fifo_wr_data_o, 0);
      chk("midrst_addr", mem_rd_addr_o, 0);
      chk("midrst_burst", mem_rd_burst_o, 0);
      exp_addr.delete();
      exp_len.delete();
      @(negedge clk) rst_n_i = 1'b1;
      for (int i = 0; i < 11; i++) begin
         mem_rd_valid_i = 1'b1;
         mem_rd_data_i = {$urandom, $urandom};
         cyc();
         chk("late_beat_dropped", fifo_wr_en_o, 1'b0);
         chk("late_beat_idle", busy_o, 1'b0);
      end
      auto_mem = 1'b1;
      run(32'h5000, 33);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
